fir_input_sequencer: RTL and testbench

- Upstream feeder for the 64-tap MAC/ALU stage.
- Holds a 64-entry coefficient bank written over a simple register port. On commit, it replays the coefficients on `b`: one discard slot, then 64 consecutive words.
- It then buffers incoming samples in a small FIFO and issues one sample on `x`/`b_valid` every SAMPLE_PERIOD cycles. This paces the input to the ALU's one-sample-per-64-MAC-cycles rate.

---
 rtl/fir_input_sequencer_if.sv | 34 +++
 rtl/fir_input_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_fir_input_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_input_sequencer_if.sv
// Bus bundle between the FIR input sequencer, its host and the downstream MAC/ALU.
// The host drives the coefficient port and the sample stream; the sequencer drives b/x and status.
interface fir_input_sequencer_if #(
    parameter int unsigned TAPS       = 64,
    parameter int unsigned DW         = 16,
    parameter int unsigned FIFO_DEPTH = 16
);
    localparam int unsigned AW = $clog2(TAPS);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic                 coef_wr;
    logic [AW-1:0]        coef_addr;
    logic signed [DW-1:0] coef_data;
    logic                 coef_commit;
    logic signed [DW-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [DW-1:0] b;
    logic signed [DW-1:0] x;
    logic                 b_valid;
    logic                 coef_done;
    logic [LW-1:0]        fifo_level;
    logic                 err_sticky;

    modport master (
        output coef_wr, coef_addr, coef_data, coef_commit, s_data, s_valid,
        input  s_ready, b, x, b_valid, coef_done, fifo_level, err_sticky
    );

    modport slave (
        input  coef_wr, coef_addr, coef_data, coef_commit, s_data, s_valid,
        output s_ready, b, x, b_valid, coef_done, fifo_level, err_sticky
    );
endinterface

// File: rtl/fir_input_sequencer.sv
// Coefficient bank replay followed by paced sample issue to the 64-tap MAC/ALU.
// Build option FIR_IN_ZEROPAD_EN: on underrun issue x=0 at the period boundary instead of stalling.
module fir_input_sequencer #(
    parameter int unsigned TAPS          = 64,
    parameter int unsigned DW            = 16,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned SAMPLE_PERIOD = 64
) (
    input  logic                 clk1,
    input  logic                 IN_rest,
    fir_input_sequencer_if.slave bus
);
    localparam int unsigned AW = $clog2(TAPS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned CW = $clog2(SAMPLE_PERIOD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRELOAD,
        S_COEF_OUT,
        S_STREAM
    } state_t;

    state_t               r_state;
    logic [AW-1:0]        r_k;
    logic [CW-1:0]        r_pc;
    logic signed [DW-1:0] r_b;
    logic signed [DW-1:0] r_x;
    logic                 r_b_valid;
    logic                 r_coef_done;
    logic                 r_err;
    logic signed [DW-1:0] r_bank [TAPS];
    logic signed [DW-1:0] r_fifo [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_level;

    state_t               w_state_nxt;
    logic [AW-1:0]        w_k_nxt;
    logic [CW-1:0]        w_pc_nxt;
    logic signed [DW-1:0] w_b_nxt;
    logic signed [DW-1:0] w_x_nxt;
    logic                 w_b_valid_nxt;
    logic                 w_done_nxt;
    logic                 w_err_nxt;
    logic                 w_bank_we;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_full;

    assign w_full = (r_level == LW'(FIFO_DEPTH));
    assign w_push = bus.s_valid && !w_full;

    // Next-state and registered-output decode
    always_comb begin
        w_state_nxt   = r_state;
        w_k_nxt       = r_k;
        w_pc_nxt      = r_pc;
        w_b_nxt       = r_b;
        w_x_nxt       = r_x;
        w_b_valid_nxt = 1'b0;
        w_done_nxt    = r_coef_done;
        w_err_nxt     = r_err;
        w_bank_we     = 1'b0;
        w_pop         = 1'b0;

        if ((r_state != S_IDLE) && (bus.coef_wr || bus.coef_commit)) begin
            w_err_nxt = 1'b1;
        end
        if (bus.s_valid && w_full) begin
            w_err_nxt = 1'b1;
        end

        unique case (r_state)
            S_IDLE: begin
                w_bank_we = bus.coef_wr;
                if (bus.coef_commit) begin
                    w_state_nxt = S_PRELOAD;
                    w_b_nxt     = '0;
                end
            end
            S_PRELOAD: begin
                // Bank write from the commit cycle has landed by now
                w_state_nxt = S_COEF_OUT;
                w_k_nxt     = '0;
                w_b_nxt     = r_bank[0];
            end
            S_COEF_OUT: begin
                if (r_k == AW'(TAPS - 1)) begin
                    w_state_nxt = S_STREAM;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_k_nxt = r_k + AW'(1);
                    w_b_nxt = r_bank[r_k + AW'(1)];
                end
            end
            S_STREAM: begin
                if (r_pc == '0) begin
                    // Level is registered, so a sample pushed this cycle pops next cycle
                    if (r_level != '0) begin
                        w_pop         = 1'b1;
                        w_x_nxt       = r_fifo[r_rd_ptr];
                        w_b_valid_nxt = 1'b1;
                        w_pc_nxt      = CW'(1);
                    end
`ifdef FIR_IN_ZEROPAD_EN
                    else begin
                        w_x_nxt       = '0;
                        w_b_valid_nxt = 1'b1;
                        w_pc_nxt      = CW'(1);
                    end
`endif
                end else if (r_pc == CW'(SAMPLE_PERIOD - 1)) begin
                    w_pc_nxt = '0;
                end else begin
                    w_pc_nxt = r_pc + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, outputs and FIFO bookkeeping
    always_ff @(posedge clk1 or posedge IN_rest) begin
        if (IN_rest) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_pc        <= '0;
            r_b         <= '0;
            r_x         <= '0;
            r_b_valid   <= 1'b0;
            r_coef_done <= 1'b0;
            r_err       <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_pc        <= w_pc_nxt;
            r_b         <= w_b_nxt;
            r_x         <= w_x_nxt;
            r_b_valid   <= w_b_valid_nxt;
            r_coef_done <= w_done_nxt;
            r_err       <= w_err_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Coefficient bank, writable only while idle
    always_ff @(posedge clk1 or posedge IN_rest) begin
        if (IN_rest) begin
            for (int i = 0; i < int'(TAPS); i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_bank_we) begin
            r_bank[bus.coef_addr] <= bus.coef_data;
        end
    end

    // Sample storage; occupancy tracking above makes a reset unnecessary here
    always_ff @(posedge clk1) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.s_data;
        end
    end

    assign bus.s_ready    = !w_full;
    assign bus.b          = r_b;
    assign bus.x          = r_x;
    assign bus.b_valid    = r_b_valid;
    assign bus.coef_done  = r_coef_done;
    assign bus.fifo_level = r_level;
    assign bus.err_sticky = r_err;

endmodule

// File: tb/tb_fir_input_sequencer.sv
// Directed + randomized bench for fir_input_sequencer; sample issue is predicted from
// push times and the period rule using queues, coefficient replay from a bank array.
module tb_fir_input_sequencer;
    localparam int unsigned TAPS = 64;
    localparam int unsigned DW   = 16;
    localparam int unsigned FD   = 16;
    localparam int unsigned SP   = 64;

    logic clk1 = 1'b0;
    logic IN_rest;

    fir_input_sequencer_if #(.TAPS(TAPS), .DW(DW), .FIFO_DEPTH(FD)) bus ();

    fir_input_sequencer #(
        .TAPS(TAPS), .DW(DW), .FIFO_DEPTH(FD), .SAMPLE_PERIOD(SP)
    ) dut (
        .clk1    (clk1),
        .IN_rest (IN_rest),
        .bus     (bus)
    );

    always #5 clk1 = ~clk1;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    logic [DW-1:0] cm [TAPS];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        bus.coef_wr     = 1'b0;
        bus.coef_addr   = '0;
        bus.coef_data   = '0;
        bus.coef_commit = 1'b0;
        bus.s_valid     = 1'b0;
        bus.s_data      = '0;
    endtask

    task automatic chk_reset(input string t);
        chk({t, ".b"},       DW'(bus.b),          DW'(0));
        chk({t, ".x"},       DW'(bus.x),          DW'(0));
        chk({t, ".b_valid"}, DW'(bus.b_valid),    DW'(0));
        chk({t, ".done"},    DW'(bus.coef_done),  DW'(0));
        chk({t, ".err"},     DW'(bus.err_sticky), DW'(0));
        chk({t, ".level"},   DW'(bus.fifo_level), DW'(0));
        chk({t, ".s_ready"}, DW'(bus.s_ready),    DW'(1));
    endtask

    task automatic do_reset(input string t);
        idle_inputs();
        IN_rest = 1'b1;
        #1;
        chk_reset(t);
        step();
        step();
        IN_rest = 1'b0;
    endtask

    task automatic write_bank(input bool_rand, input bit commit_with_last);
        for (int i = 0; i < int'(TAPS); i++) begin
            cm[i]         = bool_rand ? DW'($urandom) : DW'(i + 1);
            bus.coef_wr   = 1'b1;
            bus.coef_addr = 6'(i);
            bus.coef_data = cm[i];
            if (i == int'(TAPS) - 1 && commit_with_last) begin
                bus.coef_commit = 1'b1;
            end else begin
                step();
            end
        end
        if (!commit_with_last) begin
            idle_inputs();
            bus.coef_commit = 1'b1;
        end
    endtask

    // Caller has the commit pulse on the bus; checks PRELOAD then every replay slot
    task automatic replay(input int wr_slot, input int abort_slot);
        step();
        idle_inputs();
        chk("preload.b", DW'(bus.b), DW'(0));
        for (int k = 0; k < int'(TAPS); k++) begin
            step();
            idle_inputs();
            chk($sformatf("slot%0d.b", k), DW'(bus.b), cm[k]);
            if (k == abort_slot) begin
                #2;
                IN_rest = 1'b1;
                #1;
                chk_reset("abort");
                step();
                IN_rest = 1'b0;
                return;
            end
            if (k == int'(TAPS) - 1) begin
                chk("done_before_end", DW'(bus.coef_done), DW'(0));
            end
            if (k == wr_slot) begin
                bus.coef_wr   = 1'b1;
                bus.coef_addr = 6'd5;
                bus.coef_data = ~cm[5];
            end
        end
        step();
        chk("done_after", DW'(bus.coef_done), DW'(1));
        chk("b_hold",     DW'(bus.b),         cm[TAPS-1]);
    endtask

    // Issue rule: sample issues at the first edge that is at least one edge after its push,
    // not before the previous issue + SP, and not before the first STREAM edge.
    task automatic stream_run(input int ncyc);
        int            pq[$];
        logic [DW-1:0] dq[$];
        int            next_ok;
        int            lvl;
        int            e;
        logic [DW-1:0] xe;
        logic [DW-1:0] sd;
        logic          ve;
        logic          erre;
        bit            sv;
        bit            acc;
        next_ok = cyc + 1;
        lvl     = 0;
        xe      = '0;
        erre    = 1'b0;
        for (int n = 0; n < ncyc; n++) begin
            sv = 1'b0;
            sd = DW'($urandom);
            if (n == 0)                     begin sv = 1'b1; sd = 16'h0100; end
            else if (n == 1)                begin sv = 1'b1; sd = 16'hFF00; end
            else if (n == 2)                begin sv = 1'b1; sd = 16'h7FFF; end
            else if (n == 260)              begin sv = 1'b1; sd = 16'h1234; end
            else if (n >= 400 && n < 900)   sv = ($urandom_range(0, 29) == 0);
            else if (n >= 900 && n < 920)   sv = 1'b1;
            e   = cyc + 1;
            acc = sv && (lvl < int'(FD));
            if (sv && !acc) erre = 1'b1;
            ve = 1'b0;
            if (e >= next_ok) begin
                if (pq.size() > 0 && pq[0] <= e - 1) begin
                    ve = 1'b1;
                    xe = dq.pop_front();
                    void'(pq.pop_front());
                    lvl--;
                    next_ok = e + int'(SP);
                end
`ifdef FIR_IN_ZEROPAD_EN
                else begin
                    ve = 1'b1;
                    xe = '0;
                    next_ok = e + int'(SP);
                end
`endif
            end
            if (acc) begin
                pq.push_back(e);
                dq.push_back(sd);
                lvl++;
            end
            bus.s_valid = sv;
            bus.s_data  = sd;
            step();
            bus.s_valid = 1'b0;
            chk($sformatf("c%0d.b_valid", n), DW'(bus.b_valid),    DW'(ve));
            chk($sformatf("c%0d.x", n),       DW'(bus.x),          xe);
            chk($sformatf("c%0d.level", n),   DW'(bus.fifo_level), DW'(lvl));
            chk($sformatf("c%0d.s_ready", n), DW'(bus.s_ready),    DW'(lvl < int'(FD)));
            chk($sformatf("c%0d.err", n),     DW'(bus.err_sticky), DW'(erre));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset("rst0");

        // Fill the FIFO while idle: nothing drains, 17th push overflows
        for (int i = 0; i < 17; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = DW'($urandom);
            step();
            if (i == 14) chk("fill15.s_ready", DW'(bus.s_ready), DW'(1));
            if (i == 15) begin
                chk("fill16.s_ready", DW'(bus.s_ready),    DW'(0));
                chk("fill16.level",   DW'(bus.fifo_level), DW'(16));
                chk("fill16.err",     DW'(bus.err_sticky), DW'(0));
            end
        end
        bus.s_valid = 1'b0;
        chk("fill17.err",     DW'(bus.err_sticky), DW'(1));
        chk("fill17.level",   DW'(bus.fifo_level), DW'(16));
        chk("fill17.b_valid", DW'(bus.b_valid),    DW'(0));

        // Ramp coefficients, then stream directed + random samples
        do_reset("rst1");
        write_bank(1'b0, 1'b0);
        replay(-1, -1);
        chk("ramp.err", DW'(bus.err_sticky), DW'(0));
        stream_run(2100);

        // Write during replay is ignored and flagged; last write shares the commit cycle
        do_reset("rst2");
        write_bank(1'b1, 1'b1);
        replay(2, -1);
        chk("wr_in_coef_out.err", DW'(bus.err_sticky), DW'(1));

        // Abort mid-replay, then replay a cleared bank
        do_reset("rst3");
        write_bank(1'b1, 1'b0);
        replay(-1, 30);
        for (int i = 0; i < int'(TAPS); i++) cm[i] = '0;
        bus.coef_commit = 1'b1;
        replay(-1, -1);
        chk("zeros.err", DW'(bus.err_sticky), DW'(0));

        // Commit while streaming is ignored but flagged
        bus.coef_commit = 1'b1;
        step();
        idle_inputs();
        chk("commit_in_stream.err",  DW'(bus.err_sticky), DW'(1));
        chk("commit_in_stream.done", DW'(bus.coef_done),  DW'(1));
        chk("commit_in_stream.b",    DW'(bus.b),          DW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
